// File: rtl/rv_alu_controller.sv
// Multi-cycle RV32I control unit: fetches over req/ack, decodes R-type ALU ops and LUI,
// and sequences register addresses, ALU op and writeback for an external datapath.
module rv_alu_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs_1,
  output logic [4:0]  rs_2,
  output logic [4:0]  rd_0,
  output logic [2:0]  alu_control,
  output logic        write_rb,
  output logic [31:0] writedata,
  input  logic [31:0] alu_result,
  output logic        retired,
  output logic        halted,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]  aluc_q, aluc_d;
  logic        lui_q, lui_d;
  logic [31:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic        ret_q, ret_d;
  logic        halt_q, halt_d;

  logic        dec_legal, dec_lui;
  logic [2:0]  dec_op;

  always_comb begin
    dec_legal = 1'b0;
    dec_lui   = 1'b0;
    dec_op    = 3'b000;
    if (ir_q[6:0] == 7'b0110011) begin
      dec_legal = 1'b1;
      case ({ir_q[31:25], ir_q[14:12]})
        {7'h00, 3'b000}: dec_op = 3'b000;
        {7'h20, 3'b000}: dec_op = 3'b001;
        {7'h00, 3'b001}: dec_op = 3'b101;
        {7'h00, 3'b010}: dec_op = 3'b111;
        {7'h00, 3'b100}: dec_op = 3'b100;
        {7'h00, 3'b101}: dec_op = 3'b110;
        {7'h00, 3'b110}: dec_op = 3'b011;
        {7'h00, 3'b111}: dec_op = 3'b010;
        default:         dec_legal = 1'b0;
      endcase
    end else if (ir_q[6:0] == 7'b0110111) begin
      dec_legal = 1'b1;
      dec_lui   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= 32'h0;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      aluc_q  <= 3'd0;
      lui_q   <= 1'b0;
      wd_q    <= 32'h0;
      we_q    <= 1'b0;
      ret_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      aluc_q  <= aluc_d;
      lui_q   <= lui_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      ret_q   <= ret_d;
      halt_q  <= halt_d;
    end
  end

  // Acks are only honoured while the request is actually on the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (req_q && imem_ack) state_d = S_DECODE;
      S_DECODE:    state_d = dec_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  always_comb begin
    ir_d   = ir_q;
    pc_d   = pc_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    aluc_d = aluc_q;
    lui_d  = lui_q;
    wd_d   = wd_q;
    req_d  = (state_d == S_FETCH);
    we_d   = 1'b0;
    ret_d  = 1'b0;
    halt_d = halt_q | (state_d == S_HALT);
    case (state_q)
      S_FETCH: if (req_q && imem_ack) ir_d = imem_rdata;
      S_DECODE: if (dec_legal) begin
        rs1_d  = dec_lui ? 5'd0 : ir_q[19:15];
        rs2_d  = dec_lui ? 5'd0 : ir_q[24:20];
        rd_d   = ir_q[11:7];
        aluc_d = dec_op;
        lui_d  = dec_lui;
      end
      S_EXECUTE: begin
        wd_d  = lui_q ? {ir_q[31:12], 12'h000} : alu_result;
        we_d  = (rd_q != 5'd0);
        ret_d = 1'b1;
      end
      S_WRITEBACK: pc_d = pc_q + 32'd4;
      default: ;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign rs_1        = rs1_q;
  assign rs_2        = rs2_q;
  assign rd_0        = rd_q;
  assign alu_control = aluc_q;
  assign write_rb    = we_q;
  assign writedata   = wd_q;
  assign retired     = ret_q;
  assign halted      = halt_q;

endmodule

// File: tb/tb_rv_alu_controller.sv
// Bench for rv_alu_controller: directed test-plan steps plus a randomized instruction stream
// checked against an instruction-level reference model.
module tb_rv_alu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [4:0]  rs_1, rs_2, rd_0;
  logic [2:0]  alu_control;
  logic        write_rb;
  logic [31:0] writedata;
  logic [31:0] alu_result = 32'h0;
  logic        retired;
  logic        halted;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc = 32'h0;

  rv_alu_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .rs_1(rs_1), .rs_2(rs_2),
    .rd_0(rd_0), .alu_control(alu_control), .write_rb(write_rb),
    .writedata(writedata), .alu_result(alu_result), .retired(retired),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legal R-type table: {funct7, funct3, alu op}
  function automatic logic [12:0] rtab(input int i);
    case (i)
      0: return {7'h00, 3'b000, 3'b000}; // add
      1: return {7'h20, 3'b000, 3'b001}; // sub
      2: return {7'h00, 3'b111, 3'b010}; // and
      3: return {7'h00, 3'b110, 3'b011}; // or
      4: return {7'h00, 3'b100, 3'b100}; // xor
      5: return {7'h00, 3'b001, 3'b101}; // sll
      6: return {7'h00, 3'b101, 3'b110}; // srl
      default: return {7'h00, 3'b010, 3'b111}; // slt
    endcase
  endfunction

  task automatic ref_decode(input logic [31:0] ins, output bit legal, output bit lui,
                            output logic [4:0] r1, output logic [4:0] r2,
                            output logic [4:0] rd, output logic [2:0] op);
    logic [12:0] e;
    legal = 0; lui = 0; op = 3'd0;
    r1 = ins[19:15]; r2 = ins[24:20]; rd = ins[11:7];
    if (ins[6:0] == 7'b0110111) begin
      legal = 1; lui = 1; r1 = 0; r2 = 0;
    end else if (ins[6:0] == 7'b0110011) begin
      for (int i = 0; i < 8; i++) begin
        e = rtab(i);
        if (e[12:6] == ins[31:25] && e[5:3] == ins[14:12]) begin
          legal = 1; op = e[2:0];
        end
      end
    end
  endtask

  function automatic logic [31:0] enc_r(input int idx, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [4:0] rd);
    logic [12:0] e;
    e = rtab(idx);
    return {e[12:6], r2, r1, e[5:3], rd, 7'b0110011};
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int waits, input logic [31:0] aluv);
    bit legal, lui;
    logic [4:0] r1, r2, rd;
    logic [2:0] op;
    logic [31:0] ewd;
    int guard;
    ref_decode(ins, legal, lui, r1, r2, rd, op);
    guard = 0;
    while (imem_req !== 1'b1 && guard < 4) begin @(negedge clk); guard++; end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, model_pc);
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, model_pc);
    end
    imem_ack = 1'b1; imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    chk("decode_req_drop", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    if (!legal) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, model_pc);
      for (int k = 0; k < 3; k++) begin
        imem_ack = 1'b1;
        @(negedge clk);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_no_req", {31'd0, imem_req}, 32'd0);
        chk("halt_no_write", {30'd0, write_rb, retired}, 32'd0);
        chk("halt_pc_hold", pc, model_pc);
      end
      imem_ack = 1'b0;
      return;
    end
    chk("exec_not_halted", {31'd0, halted}, 32'd0);
    chk("exec_rs1", {27'd0, rs_1}, {27'd0, r1});
    chk("exec_rs2", {27'd0, rs_2}, {27'd0, r2});
    chk("exec_rd", {27'd0, rd_0}, {27'd0, rd});
    chk("exec_aluc", {29'd0, alu_control}, {29'd0, op});
    chk("exec_no_wb", {30'd0, write_rb, retired}, 32'd0);
    alu_result = aluv;
    ewd = lui ? {ins[31:12], 12'h000} : aluv;
    @(negedge clk);
    alu_result = $urandom;
    chk("wb_we", {31'd0, write_rb}, {31'd0, rd != 5'd0});
    chk("wb_data", writedata, ewd);
    chk("wb_retired", {31'd0, retired}, 32'd1);
    model_pc = model_pc + 32'd4;
    @(negedge clk);
    chk("next_fetch_pc", pc, model_pc);
    chk("next_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("next_pulse_clear", {30'd0, write_rb, retired}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_ctl"}, {imem_req, write_rb, retired, halted, alu_control}, 32'h0);
    chk({tag, "_regs"}, {17'd0, rs_1, rs_2, rd_0}, 32'h0);
    chk({tag, "_wdata"}, writedata, 32'h0);
  endtask

  initial begin
    logic [31:0] ins;
    int kind;
    rst_n = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    model_pc = 32'h0;

    run_instr(32'h002081B3, 0, 32'd7);
    run_instr(32'h40208233, 3, 32'hFFFF_FFFF);
    run_instr(32'h123452B7, 1, 32'hDEAD_BEEF);
    run_instr(32'h00208033, 0, 32'h0000_0055);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)
        ins = enc_r($urandom_range(0, 7), 5'($urandom), 5'($urandom), 5'($urandom));
      else if (kind < 9)
        ins = {20'($urandom), 5'($urandom), 7'b0110111};
      else
        ins = enc_r($urandom_range(0, 7), 5'($urandom), 5'($urandom), 5'd0);
      run_instr(ins, $urandom_range(0, 3), $urandom);
    end
    run_instr(32'h0020B1B3, 0, 32'h0);

    rst_n = 1'b0; #1;
    check_reset_vals("reset_from_halt");
    @(negedge clk); rst_n = 1'b1; model_pc = 32'h0;
    run_instr(32'h002081B3, 0, 32'd11);
    run_instr(32'h40208233, 2, 32'd3);
    run_instr(32'h00000013, 0, 32'h0);

    rst_n = 1'b0; #1; @(negedge clk); rst_n = 1'b1; model_pc = 32'h0;
    while (imem_req !== 1'b1 && checks < 100000) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h002081B3;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); alu_result = 32'h1234;
    @(negedge clk);
    chk("pre_reset_we", {31'd0, write_rb}, 32'd1);
    rst_n = 1'b0; #1;
    chk("midwb_we_drop", {31'd0, write_rb}, 32'd0);
    chk("midwb_ret_drop", {31'd0, retired}, 32'd0);
    check_reset_vals("midwb");
    @(negedge clk); rst_n = 1'b1; model_pc = 32'h0;
    run_instr(32'h123452B7, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
